// File: rtl/sipo_deser_if.sv
// Bundle of the serial input, the valid/ready word output and the status flags
// of the deserializer. The master side feeds bits and consumes words; the
// slave side is the deserializer itself.
interface sipo_deser_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  din;
  logic                  din_en;
  logic                  sof;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  locked;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output din, din_en, sof, out_ready,
    input  out_data, out_valid, locked, frame_err, overrun
  );

  modport slave (
    input  din, din_en, sof, out_ready,
    output out_data, out_valid, locked, frame_err, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: MSB-first bit capture aligned by a
// start-of-frame strobe, with a one-entry valid/ready output register,
// framing-error pulse and sticky overrun flag.
module sipo_deser #(
  parameter int DATA_WIDTH = 4
) (
  input logic        clk,
  input logic        rst_n,  // active-high synchronous reset despite the name
  sipo_deser_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [0:0] HUNT  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  frame_err_reg;
  logic                  overrun_reg;

  logic [DATA_WIDTH-1:0] shifted;
  logic                  accept;
  logic                  restart;
  logic                  mid_word_sof;
  logic                  word_done;

  // Decode what the current accepted bit does to the framing state.
  always_comb begin
    shifted      = {shift_reg[DATA_WIDTH-2:0], bus.din};
    accept       = bus.din_en;
    mid_word_sof = accept && bus.sof && (state_reg == SHIFT) && (count_reg != '0);
    // sof at a word boundary in SHIFT is an ordinary MSB, so only HUNT entry
    // and a mid-word sof need the explicit reload path.
    restart      = accept && bus.sof && ((state_reg == HUNT) || (count_reg != '0));
    word_done    = accept && (state_reg == SHIFT) && !restart && (count_reg == LAST_CNT);
  end

  // Framing state machine, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg     <= HUNT;
      count_reg     <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= mid_word_sof;
      if (restart) begin
        shift_reg <= {{(DATA_WIDTH-1){1'b0}}, bus.din};
        count_reg <= CNT_W'(1);
        state_reg <= SHIFT;
      end else if (accept && (state_reg == SHIFT)) begin
        shift_reg <= shifted;
        count_reg <= word_done ? '0 : count_reg + CNT_W'(1);
      end
    end
  end

  // One-entry output register; a full, unconsumed slot drops the new word.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (word_done) begin
      if (!valid_reg || bus.out_ready) begin
        data_reg  <= shifted;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (valid_reg && bus.out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.out_data  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.locked    = (state_reg == SHIFT);
  assign bus.frame_err = frame_err_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser with DATA_WIDTH = 4.
module tb_sipo_deser;

  logic clk;
  logic rst_n;
  int   chk_cnt;
  int   pass_cnt;

  logic       mon_en;
  logic [3:0] beats[$];

  sipo_deser_if #(.DATA_WIDTH(4)) bus ();

  sipo_deser #(.DATA_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record consumed words away from the active edge.
  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      beats.push_back(bus.out_data);
      $display("beat data=%h", bus.out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    bus.din    = b;
    bus.sof    = s;
    bus.din_en = 1'b1;
    tick();
    bus.din_en = 1'b0;
    bus.sof    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input logic with_sof);
    for (int i = 3; i >= 0; i--) send_bit(w[i], with_sof && (i == 3));
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.out_data !== 4'h0) $display("FAIL reset_data got=%h exp=0", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.locked !== 1'b0) $display("FAIL reset_locked got=%b exp=0", bus.locked); else pass_cnt++;
    chk_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); else pass_cnt++;
    chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
  endtask

  task automatic test_single_word();
    bus.out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    chk_cnt++; if (bus.locked !== 1'b1) $display("FAIL single_locked got=%b exp=1", bus.locked); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL single_valid_bit3 got=%b exp=0", bus.out_valid); else pass_cnt++;
    send_bit(1'b1, 1'b0);
    $display("single word sent 1011");
    chk_cnt++; if (bus.out_data !== 4'hB) $display("FAIL single_data got=%h exp=b", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL single_frame_err got=%b exp=0", bus.frame_err); else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL single_consumed got=%b exp=0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.out_data !== 4'hB) $display("FAIL single_data_hold got=%h exp=b", bus.out_data); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [3:0] words[3];
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hF;
    beats.delete();
    bus.out_ready = 1'b1;
    mon_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      for (int i = 3; i >= 0; i--) begin
        // Idle gaps carry junk din and sof that must be ignored.
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          bus.din = 1'($urandom_range(0, 1));
          bus.sof = 1'b1;
          tick();
          bus.sof = 1'b0;
        end
        send_bit(words[w][i], (w == 0) && (i == 3));
      end
      $display("stream word %h sent", words[w]);
    end
    tick();
    tick();
    mon_en = 1'b0;
    bus.out_ready = 1'b0;
    chk_cnt++; if (beats.size() !== 3) $display("FAIL stream_count got=%0d exp=3", beats.size()); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (k >= beats.size()) $display("FAIL stream_beat%0d got=none exp=%h", k, words[k]);
      else if (beats[k] !== words[k]) $display("FAIL stream_beat%0d got=%h exp=%h", k, beats[k], words[k]);
      else pass_cnt++;
    end
    chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL stream_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send_word(4'h3, 1'b0);
    $display("backpressure word 3 sent");
    chk_cnt++; if (bus.out_data !== 4'h3) $display("FAIL bp_first_data got=%h exp=3", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL bp_first_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
    send_word(4'hC, 1'b0);
    $display("backpressure word c sent");
    chk_cnt++; if (bus.out_data !== 4'h3) $display("FAIL bp_hold_data got=%h exp=3", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.overrun !== 1'b1) $display("FAIL bp_overrun got=%b exp=1", bus.overrun); else pass_cnt++;
    beats.delete();
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    mon_en = 1'b0;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", bus.out_valid); else pass_cnt++;
    chk_cnt++;
    if (beats.size() !== 1) $display("FAIL bp_consume_count got=%0d exp=1", beats.size());
    else if (beats[0] !== 4'h3) $display("FAIL bp_consume_data got=%h exp=3", beats[0]);
    else pass_cnt++;
    tick();
    chk_cnt++; if (bus.overrun !== 1'b1) $display("FAIL bp_overrun_sticky got=%b exp=1", bus.overrun); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.out_ready = 1'b0;
    send_word(4'h1, 1'b1);
    $display("simultaneous word 1 sent");
    chk_cnt++; if (bus.out_data !== 4'h1) $display("FAIL sim_first_data got=%h exp=1", bus.out_data); else pass_cnt++;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    bus.out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    bus.out_ready = 1'b0;
    $display("simultaneous word 2 sent");
    chk_cnt++; if (bus.out_data !== 4'h2) $display("FAIL sim_data got=%h exp=2", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL sim_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.overrun !== 1'b0) $display("FAIL sim_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    $display("mid-word sof sent");
    chk_cnt++; if (bus.frame_err !== 1'b1) $display("FAIL fe_pulse got=%b exp=1", bus.frame_err); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL fe_partial_out got=%b exp=0", bus.out_valid); else pass_cnt++;
    send_bit(1'b1, 1'b0);
    chk_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL fe_pulse_width got=%b exp=0", bus.frame_err); else pass_cnt++;
    send_bit(1'b1, 1'b0);
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL fe_early_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    send_bit(1'b0, 1'b0);
    $display("realigned word 6 sent");
    chk_cnt++; if (bus.out_data !== 4'h6) $display("FAIL fe_data got=%h exp=6", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL fe_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] junk;
    junk = 8'b1011_0101;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_reset();
    $display("reset mid-word");
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rm_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.out_data !== 4'h0) $display("FAIL rm_data got=%h exp=0", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.locked !== 1'b0) $display("FAIL rm_locked got=%b exp=0", bus.locked); else pass_cnt++;
    for (int i = 7; i >= 0; i--) begin
      send_bit(junk[i], 1'b0);
      chk_cnt++;
      if (bus.out_valid !== 1'b0 || bus.locked !== 1'b0)
        $display("FAIL hunt_bit%0d valid=%b locked=%b exp=0,0", i, bus.out_valid, bus.locked);
      else pass_cnt++;
    end
    send_word(4'h9, 1'b1);
    $display("post-reset word 9 sent");
    chk_cnt++; if (bus.out_data !== 4'h9) $display("FAIL rm_recover_data got=%h exp=9", bus.out_data); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL rm_recover_valid got=%b exp=1", bus.out_valid); else pass_cnt++;
  endtask

  initial begin
    chk_cnt       = 0;
    pass_cnt      = 0;
    mon_en        = 1'b0;
    rst_n         = 1'b1;
    bus.din       = 1'b0;
    bus.din_en    = 1'b0;
    bus.sof       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_frame_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-to-parallel deserializer: the receive end of the transceiver serial link, paired with the parallel-in/serial-out serializer. It samples one serial bit per enabled clock, MSB first, aligns words with a start-of-frame strobe, and presents each completed word on a one-entry valid/ready output register. Framing errors and output overruns are flagged.

## Interface
- DATA_WIDTH, 4, word width in bits; legal range 2 to 32.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-high despite the name: reset is applied when rst_n = 1 at a rising clk edge.
- din  input  1  serial data bit; MSB of each word arrives first.
- din_en  input  1  qualifies din; a bit is accepted only at an edge where din_en = 1.
- sof  input  1  start of frame; valid only with din_en = 1; marks the accepted bit as a word MSB.
- out_data  output  DATA_WIDTH  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data at an edge where out_valid = 1 and out_ready = 1.
- locked  output  1  word alignment established (state SHIFT).
- frame_err  output  1  one-cycle pulse: sof arrived mid-word.
- overrun  output  1  sticky: a completed word was dropped; cleared only by reset.

## Operation
- State machine with two states:
  - HUNT (reset state): accepted bits without sof are discarded. An accepted bit with sof loads that bit as the MSB, sets bit count to 1, and moves to SHIFT.
  - SHIFT: each accepted bit shifts into the LSB of the shift register (shift left), and the count increments.
- Word completion: acceptance of bit number DATA_WIDTH completes the word. The count wraps to 0 and the state stays SHIFT, so the next accepted bit is the next MSB. Back-to-back words need no further sof.
- sof with count = 0 in SHIFT is legal and silent.
- sof with count != 0 in SHIFT:
  - frame_err pulses.
  - The partial word is discarded, with no output.
  - The current bit restarts the word as MSB, and count = 1.
- Output register behaviour at a word completion:
  - out_valid = 0, or out_valid = 1 with out_ready = 1 at the same edge: load out_data and set out_valid = 1. Simultaneous consume and fill is lossless.
  - out_valid = 1 and out_ready = 0: the new word is dropped. out_data and out_valid are unchanged, and overrun is set.
- A consume with no completion at the same edge clears out_valid. out_data holds its last value.
- locked = 1 exactly while in SHIFT.
- Accepted bits with din_en = 0 do not exist. din and sof are ignored when din_en = 0, and sof without din_en does nothing.
- Reset values: state HUNT, count 0, shift register 0, out_data 0, out_valid 0, locked 0, frame_err 0, overrun 0.
- Reset mid-word discards the partial word and any pending output. Reset has priority over all other inputs.

## Timing
- All outputs are registered.
- Latency: the last bit of a word is accepted at edge N. out_data and out_valid are updated at edge N, so they are visible during cycle N+1.
- frame_err is high for exactly the one cycle following the offending edge.
- locked rises in the cycle after the first sof edge.
- Throughput: one word per DATA_WIDTH enabled cycles. No bubbles are required when out_ready is held high.
- out_data is stable while out_valid = 1 and out_ready = 0.

## Test plan
All scenarios use DATA_WIDTH = 4.
- Reset then single word:
  - Stimulus: bits 1,0,1,1 on consecutive din_en cycles, sof on the first bit.
  - Required: locked = 1 from the cycle after bit 1; out_data = 4'hB and out_valid = 1 after the 4th edge; frame_err = 0.
- Stream with out_ready held at 1:
  - Stimulus: words 4'hA, 4'h5, 4'hF sent back to back; sof only on the first bit of 4'hA; din_en gapped at random.
  - Required: three out_valid beats carrying A, 5, F in that order; overrun = 0.
- Backpressure:
  - Stimulus: out_ready = 0 while two words, 4'h3 then 4'hC, complete.
  - Required: out_data stays 4'h3 and overrun = 1. When out_ready then rises, 4'h3 is consumed once and out_valid = 0 afterwards.
- Simultaneous consume and fill:
  - Stimulus: out_valid = 1 with 4'h1 held and out_ready = 1 on the edge where 4'h2 completes.
  - Required: out_data = 4'h2, out_valid stays 1, overrun = 0.
- Framing error:
  - Stimulus: bits 1,1 followed by sof on the next bit; then bits 0,1,1,0 starting with that sof bit.
  - Required: frame_err is a one-cycle pulse; out_data = 4'h6; the partial word is never output.
- Reset mid-word and in HUNT:
  - Stimulus: 2 bits into a word, rst_n = 1 for one edge; then 8 bits without sof.
  - Required: all outputs return to 0 and locked = 0. No word is produced until a sof arrives.
